// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU ops straight through and sequences load/store
// accesses over the dmem bus with stall, misalign detection and timeout abort.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_to_reg,
    input  logic               ex_reg_we,
    input  logic [31:0]        ex_alu,
    input  logic [31:0]        ex_store_data,
    input  logic [4:0]         ex_rd,
    mem_stage_if.master        dmem,
    output logic               mem_to_reg,
    output logic               mem_reg_we,
    output logic [31:0]        mem_outMem,
    output logic [31:0]        mem_outAlu,
    output logic [4:0]         mem_rd,
    output logic               mem_stall,
    output logic               mem_err
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic             abort_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic mem_op;
    logic misaligned;

    assign mem_op     = ex_mem_read | ex_mem_write;
    assign misaligned = (ex_alu[1:0] != 2'b00);

    // Access sequencing; request fields are latched so the bus stays stable in WAIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ex_valid && mem_op && !misaligned) begin
                        state   <= S_WAIT;
                        cnt     <= '0;
                        abort_q <= 1'b0;
                        we_q    <= ex_mem_write;
                        addr_q  <= ex_alu;
                        wdata_q <= ex_store_data;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ready) begin
                        state   <= S_DONE;
                        cnt     <= '0;
                        rdata_q <= we_q ? 32'd0 : dmem.dmem_rdata;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_DONE;
                        cnt     <= '0;
                        abort_q <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    abort_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs follow the live EX/MEM slot so ALU ops and DONE results land the same cycle.
    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        mem_to_reg      = 1'b0;
        mem_reg_we      = 1'b0;
        mem_outMem      = '0;
        mem_outAlu      = '0;
        mem_rd          = '0;
        mem_stall       = 1'b0;
        mem_err         = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!mem_op) begin
                            mem_outAlu = ex_alu;
                            mem_rd     = ex_rd;
                            mem_to_reg = ex_to_reg;
                            mem_reg_we = ex_reg_we;
                        end else if (misaligned) begin
                            mem_err = 1'b1;
                        end else begin
                            dmem.dmem_req   = 1'b1;
                            dmem.dmem_we    = ex_mem_write;
                            dmem.dmem_addr  = ex_alu;
                            dmem.dmem_wdata = ex_store_data;
                            mem_stall       = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    dmem.dmem_req   = 1'b1;
                    dmem.dmem_we    = we_q;
                    dmem.dmem_addr  = addr_q;
                    dmem.dmem_wdata = wdata_q;
                    mem_stall       = 1'b1;
                end
                S_DONE: begin
                    mem_outMem = rdata_q;
                    mem_outAlu = ex_alu;
                    mem_rd     = ex_rd;
                    mem_to_reg = ex_to_reg;
                    mem_reg_we = ex_reg_we & ~abort_q & ~we_q;
                    mem_err    = abort_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts every cycle's outputs.
module tb_mem_stage;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_to_reg, ex_reg_we;
    logic [31:0] ex_alu, ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_to_reg, mem_reg_we, mem_stall, mem_err;
    logic [31:0] mem_outMem, mem_outAlu;
    logic [4:0]  mem_rd;

    int n_chk = 0;
    int n_err = 0;

    mem_stage_if dmem_bus ();

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_to_reg    (ex_to_reg),
        .ex_reg_we    (ex_reg_we),
        .ex_alu       (ex_alu),
        .ex_store_data(ex_store_data),
        .ex_rd        (ex_rd),
        .dmem         (dmem_bus),
        .mem_to_reg   (mem_to_reg),
        .mem_reg_we   (mem_reg_we),
        .mem_outMem   (mem_outMem),
        .mem_outAlu   (mem_outAlu),
        .mem_rd       (mem_rd),
        .mem_stall    (mem_stall),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req"},    32'(dmem_bus.dmem_req), 32'd0);
        check({tag, ".we"},     32'(dmem_bus.dmem_we), 32'd0);
        check({tag, ".addr"},   dmem_bus.dmem_addr, 32'd0);
        check({tag, ".wdata"},  dmem_bus.dmem_wdata, 32'd0);
        check({tag, ".stall"},  32'(mem_stall), 32'd0);
        check({tag, ".err"},    32'(mem_err), 32'd0);
        check({tag, ".reg_we"}, 32'(mem_reg_we), 32'd0);
        check({tag, ".to_reg"}, 32'(mem_to_reg), 32'd0);
        check({tag, ".rd"},     32'(mem_rd), 32'd0);
        check({tag, ".outMem"}, mem_outMem, 32'd0);
        check({tag, ".outAlu"}, mem_outAlu, 32'd0);
    endtask

    // kind: 0 bubble, 1 ALU op, 2 load, 3 store. ready_at: WAIT cycle (1-based) that sees
    // dmem_ready; any value beyond TMO means the memory never answers.
    task automatic run_op(input int kind, input logic [31:0] alu, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic to_reg, input logic reg_we,
                          input int ready_at, input logic [31:0] rdata_val);
        logic        is_ld, is_st, mis, ok;
        int          waits;
        logic [31:0] data;
        is_ld = (kind == 2);
        is_st = (kind == 3);
        mis   = (is_ld || is_st) && (alu[1:0] != 2'b00);
        data  = 32'd0;

        ex_valid      = (kind != 0);
        ex_mem_read   = (kind == 0) ? 1'($urandom_range(0, 1)) : is_ld;
        ex_mem_write  = (kind == 0) ? 1'($urandom_range(0, 1)) : is_st;
        ex_to_reg     = to_reg;
        ex_reg_we     = reg_we;
        ex_alu        = alu;
        ex_store_data = sdata;
        ex_rd         = rd;
        dmem_bus.dmem_ready = 1'($urandom_range(0, 1));
        dmem_bus.dmem_rdata = $urandom;
        @(negedge clk);

        if (kind == 0) begin
            check_all_zero("bubble");
            next_cycle();
        end else if (kind == 1) begin
            check("alu.req",    32'(dmem_bus.dmem_req), 32'd0);
            check("alu.stall",  32'(mem_stall), 32'd0);
            check("alu.err",    32'(mem_err), 32'd0);
            check("alu.outAlu", mem_outAlu, alu);
            check("alu.outMem", mem_outMem, 32'd0);
            check("alu.rd",     32'(mem_rd), 32'(rd));
            check("alu.to_reg", 32'(mem_to_reg), 32'(to_reg));
            check("alu.reg_we", 32'(mem_reg_we), 32'(reg_we));
            next_cycle();
        end else if (mis) begin
            check("mis.req",    32'(dmem_bus.dmem_req), 32'd0);
            check("mis.stall",  32'(mem_stall), 32'd0);
            check("mis.err",    32'(mem_err), 32'd1);
            check("mis.reg_we", 32'(mem_reg_we), 32'd0);
            next_cycle();
        end else begin
            check("req.req",    32'(dmem_bus.dmem_req), 32'd1);
            check("req.we",     32'(dmem_bus.dmem_we), 32'(is_st));
            check("req.addr",   dmem_bus.dmem_addr, alu);
            check("req.wdata",  dmem_bus.dmem_wdata, sdata);
            check("req.stall",  32'(mem_stall), 32'd1);
            check("req.reg_we", 32'(mem_reg_we), 32'd0);
            check("req.err",    32'(mem_err), 32'd0);
            next_cycle();

            ok    = (ready_at >= 1) && (ready_at <= int'(TMO));
            waits = ok ? ready_at : int'(TMO);
            for (int i = 1; i <= waits; i++) begin
                dmem_bus.dmem_ready = (i == ready_at);
                dmem_bus.dmem_rdata = (i == ready_at) ? rdata_val : $urandom;
                if (i == ready_at) data = rdata_val;
                @(negedge clk);
                check("wait.req",    32'(dmem_bus.dmem_req), 32'd1);
                check("wait.we",     32'(dmem_bus.dmem_we), 32'(is_st));
                check("wait.addr",   dmem_bus.dmem_addr, alu);
                check("wait.wdata",  dmem_bus.dmem_wdata, sdata);
                check("wait.stall",  32'(mem_stall), 32'd1);
                check("wait.reg_we", 32'(mem_reg_we), 32'd0);
                check("wait.err",    32'(mem_err), 32'd0);
                next_cycle();
            end

            dmem_bus.dmem_ready = 1'($urandom_range(0, 1));
            dmem_bus.dmem_rdata = $urandom;
            @(negedge clk);
            check("done.req",    32'(dmem_bus.dmem_req), 32'd0);
            check("done.stall",  32'(mem_stall), 32'd0);
            check("done.outAlu", mem_outAlu, alu);
            check("done.rd",     32'(mem_rd), 32'(rd));
            check("done.to_reg", 32'(mem_to_reg), 32'(to_reg));
            check("done.reg_we", 32'(mem_reg_we), 32'(ok && is_ld && reg_we));
            check("done.err",    32'(mem_err), 32'(!ok));
            if (ok) check("done.outMem", mem_outMem, is_ld ? data : 32'd0);
            next_cycle();
        end
    endtask

    task automatic reset_mid_wait(input int waits_before);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_to_reg = 1'b1; ex_reg_we = 1'b1;
        ex_alu = 32'h0000_0300; ex_store_data = $urandom; ex_rd = 5'd9;
        dmem_bus.dmem_ready = 1'b0;
        @(negedge clk);
        check("rstw.req", 32'(dmem_bus.dmem_req), 32'd1);
        next_cycle();
        for (int i = 0; i < waits_before; i++) begin
            @(negedge clk);
            check("rstw.stall", 32'(mem_stall), 32'd1);
            next_cycle();
        end
        rst = 1'b0;
        dmem_bus.dmem_ready = 1'b1;
        @(negedge clk);
        check_all_zero("rst_in_wait");
        next_cycle();
        @(negedge clk);
        check_all_zero("rst_held");
        next_cycle();
        rst = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_all_zero("after_rst");
        next_cycle();
    endtask

    initial begin
        int kind, rdy;
        logic [31:0] a;

        // Reset with a live ALU op on the inputs: everything must still read zero.
        rst = 1'b0;
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_to_reg = 1'b1; ex_reg_we = 1'b1;
        ex_alu = 32'hCAFE_0001; ex_store_data = 32'h1; ex_rd = 5'd3;
        dmem_bus.dmem_ready = 1'b1; dmem_bus.dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        check_all_zero("reset0");
        next_cycle();
        @(negedge clk);
        check_all_zero("reset1");
        next_cycle();
        rst = 1'b1;

        run_op(1, 32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b1, 0, 32'd0);
        run_op(2, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
        run_op(3, 32'h0000_0040, 32'hA5A5_A5A5, 5'd4, 1'b0, 1'b1, 1, 32'h1234_5678);
        run_op(2, 32'h0000_0102, 32'h0, 5'd6, 1'b1, 1'b1, 1, 32'h0);
        run_op(2, 32'h0000_0200, 32'h0, 5'd8, 1'b1, 1'b1, 99, 32'h0);
        run_op(2, 32'h0000_0204, 32'h0, 5'd8, 1'b1, 1'b1, int'(TMO), 32'h0BAD_F00D);
        reset_mid_wait(2);
        run_op(2, 32'h0000_0010, 32'h0, 5'd2, 1'b1, 1'b1, 2, 32'h0F0F_0F0F);
        run_op(0, $urandom, $urandom, 5'd1, 1'b1, 1'b1, 0, 32'h0);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            rdy  = ($urandom_range(0, 7) == 0) ? $urandom_range(int'(TMO) + 1, int'(TMO) + 4)
                                               : $urandom_range(1, 6);
            run_op(kind, a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), rdy, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
